// File: rtl/sim_checkpoint_monitor.sv
// Run-control and self-check block: counts cycles after start, triggers on a stop
// cycle, PC match or timeout, snapshots PC/probes and produces a pass/fail verdict.

module sim_checkpoint_lane #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] snap,
  input  logic [WIDTH-1:0] expv,
  output logic             mis
);
  assign mis = en && (snap != expv);
endmodule

module sim_checkpoint_monitor #(
  parameter int WIDTH      = 32,
  parameter int NUM_CHECKS = 4,
  parameter int CYCLE_W    = 32,
  parameter int TIMEOUT    = 10000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          mode_pc,
  input  logic [CYCLE_W-1:0]            stop_cycle,
  input  logic [WIDTH-1:0]              stop_pc,
  input  logic [NUM_CHECKS-1:0]         check_mask,
  input  logic [NUM_CHECKS*WIDTH-1:0]   expect_flat,
  input  logic [WIDTH-1:0]              pc,
  input  logic [NUM_CHECKS*WIDTH-1:0]   probe_flat,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [NUM_CHECKS-1:0]         fail_vec,
  output logic                          halt_req,
  output logic [CYCLE_W-1:0]            cycle_count,
  output logic [WIDTH-1:0]              snap_pc
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CMP, S_DONE} state_t;

  typedef struct packed {
    logic                                mode_pc;
    logic [CYCLE_W-1:0]                  stop_cycle;
    logic [WIDTH-1:0]                    stop_pc;
    logic [NUM_CHECKS-1:0]               mask;
    logic [NUM_CHECKS-1:0][WIDTH-1:0]    expv;
  } cfg_t;

  state_t                           state;
  cfg_t                             cfg;
  logic [NUM_CHECKS-1:0][WIDTH-1:0] snap;
  logic [NUM_CHECKS-1:0]            mis;
  logic                             trig_cyc, trig_pc, trig_to, trigger;

  assign trig_cyc = !cfg.mode_pc && (cycle_count == cfg.stop_cycle);
  assign trig_pc  =  cfg.mode_pc && (pc == cfg.stop_pc);
  assign trig_to  = (cycle_count == CYCLE_W'(TIMEOUT));
  assign trigger  = trig_cyc | trig_pc | trig_to;

  for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_lane
    sim_checkpoint_lane #(.WIDTH(WIDTH)) u_lane (
      .en   (cfg.mask[i]),
      .snap (snap[i]),
      .expv (cfg.expv[i]),
      .mis  (mis[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cfg         <= '0;
      snap        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fail_vec    <= '0;
      halt_req    <= 1'b0;
      cycle_count <= '0;
      snap_pc     <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cfg.mode_pc    <= mode_pc;
            // stop_cycle of 0 would never match a counter that starts at 1
            cfg.stop_cycle <= (stop_cycle == '0) ? CYCLE_W'(1) : stop_cycle;
            cfg.stop_pc    <= stop_pc;
            cfg.mask       <= check_mask;
            cfg.expv       <= expect_flat;
            cycle_count    <= CYCLE_W'(1);
            pass           <= 1'b0;
            timeout        <= 1'b0;
            fail_vec       <= '0;
            snap_pc        <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            halt_req       <= 1'b0;
            state          <= S_RUN;
          end
        end
        S_RUN: begin
          if (trigger) begin
            snap_pc <= pc;
            snap    <= probe_flat;
            timeout <= trig_to && !(trig_cyc || trig_pc);
            state   <= S_CMP;
          end else begin
            cycle_count <= cycle_count + CYCLE_W'(1);
          end
        end
        S_CMP: begin
          fail_vec <= mis;
          pass     <= !timeout && (mis == '0);
          busy     <= 1'b0;
          done     <= 1'b1;
          halt_req <= 1'b1;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sim_checkpoint_monitor.sv
// Bench for sim_checkpoint_monitor: directed vector table, randomized runs against a
// scan-based reference model, plus start-in-RUN and reset-in-RUN sequences.
module tb_sim_checkpoint_monitor;
  localparam int W = 32, N = 4, CW = 32, TO = 20;

  logic            clk = 0, reset = 1, start = 0, mode_pc = 0;
  logic [CW-1:0]   stop_cycle = '0;
  logic [W-1:0]    stop_pc = '0, pc = '0;
  logic [N-1:0]    check_mask = '0;
  logic [N*W-1:0]  expect_flat = '0, probe_flat = '0;
  logic            busy, done, pass, timeout, halt_req;
  logic [N-1:0]    fail_vec;
  logic [CW-1:0]   cycle_count;
  logic [W-1:0]    snap_pc;

  int n_chk = 0, n_fail = 0;
  logic [W-1:0]   pcs  [64];
  logic [N*W-1:0] prbs [64];

  sim_checkpoint_monitor #(.WIDTH(W), .NUM_CHECKS(N), .CYCLE_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_pc(mode_pc), .stop_cycle(stop_cycle),
    .stop_pc(stop_pc), .check_mask(check_mask), .expect_flat(expect_flat), .pc(pc),
    .probe_flat(probe_flat), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .fail_vec(fail_vec), .halt_req(halt_req), .cycle_count(cycle_count), .snap_pc(snap_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           m;
    logic [31:0]    sc, spc;
    logic [3:0]     mask;
    logic [127:0]   ev, prb;
    logic [31:0]    base, step;
    int             e_trig;
    logic           e_pass, e_to;
    logic [3:0]     e_fv;
    logic [31:0]    e_snap;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic arm(input logic m, input logic [31:0] sc, input logic [31:0] spc,
                     input logic [3:0] mask, input logic [127:0] ev);
    @(negedge clk);
    mode_pc = m; stop_cycle = sc; stop_pc = spc; check_mask = mask; expect_flat = ev;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    // scramble config inputs: the monitor must use the values latched at start
    mode_pc = ~m; stop_cycle = sc + 3; stop_pc = ~spc; check_mask = ~mask; expect_flat = ~ev;
  endtask

  task automatic run(input string nm, input logic m, input logic [31:0] sc,
                     input logic [31:0] spc, input logic [3:0] mask, input logic [127:0] ev,
                     input int e_trig, input logic e_pass, input logic e_to,
                     input logic [3:0] e_fv, input logic [31:0] e_snap);
    int lat;
    arm(m, sc, spc, mask, ev);
    chk({nm, " armed"}, 128'({busy, done, pass, timeout, halt_req, fail_vec, snap_pc, cycle_count}),
        128'({1'b1, 4'b0, 4'b0, 32'd0, 32'd1}));
    lat = 0;
    for (int e = 1; e <= 60; e++) begin
      pc = pcs[e]; probe_flat = prbs[e];
      @(posedge clk); #1;
      if (done) begin lat = e; break; end
    end
    chk({nm, " latency"}, 128'(lat), 128'(e_trig + 1));
    chk({nm, " cycle_count"}, 128'(cycle_count), 128'(e_trig));
    chk({nm, " verdict"}, 128'({pass, timeout, fail_vec, halt_req, busy}),
        128'({e_pass, e_to, e_fv, 1'b1, 1'b0}));
    chk({nm, " snap_pc"}, 128'(snap_pc), 128'(e_snap));
    @(posedge clk); #1;
    chk({nm, " hold"}, 128'({done, pass, timeout, fail_vec, cycle_count}),
        128'({1'b1, e_pass, e_to, e_fv, 32'(e_trig)}));
  endtask

  // Reference: scan the per-cycle pc trace for the first cycle meeting a stop rule
  function automatic void model(input logic m, input logic [31:0] sc, input logic [31:0] spc,
                                input logic [3:0] mask, input logic [127:0] ev,
                                output int k, output logic p, output logic to,
                                output logic [3:0] fv, output logic [31:0] sp);
    int tgt;
    logic hit;
    tgt = (sc == 0) ? 1 : int'(sc);
    k = TO;
    for (int c = 1; c <= TO; c++) begin
      if ((!m && c == tgt) || (m && pcs[c] == spc)) begin k = c; break; end
    end
    hit = (!m && k == tgt) || (m && pcs[k] == spc);
    to = !hit;
    sp = pcs[k];
    for (int i = 0; i < N; i++) fv[i] = mask[i] && (prbs[k][i*W +: W] != ev[i*W +: W]);
    p = !to && (fv == 4'b0);
  endfunction

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 10, 0,    4'b0001, {96'd0, 32'd32}, {96'd0, 32'd32}, 200, 1, 10, 1, 0, 4'b0000, 209};
    tbl[1] = '{1'b0, 10, 0,    4'b0101, {32'd0, 32'd7, 32'd0, 32'd33}, {32'd0, 32'd7, 32'd0, 32'd32},
               200, 1, 10, 0, 0, 4'b0001, 209};
    tbl[2] = '{1'b0, 10, 0,    4'b0000, {32'd0, 32'd7, 32'd0, 32'd33}, {32'd0, 32'd7, 32'd0, 32'd32},
               200, 1, 10, 1, 0, 4'b0000, 209};
    tbl[3] = '{1'b1, 2,  1108, 4'b0000, 128'd0, 128'd0, 1100, 4, 3,  1, 0, 4'b0000, 1108};
    tbl[4] = '{1'b1, 2,  5,    4'b0000, 128'd0, 128'd0, 1100, 4, 20, 0, 1, 4'b0000, 1176};
    tbl[5] = '{1'b0, 20, 0,    4'b0001, {96'd0, 32'd5}, {96'd0, 32'd5}, 0, 8, 20, 1, 0, 4'b0000, 152};
    tbl[6] = '{1'b0, 0,  0,    4'b1111, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd1, 32'd2, 32'd3, 32'd4},
               40, 4, 1, 1, 0, 4'b0000, 40};
    tbl[7] = '{1'b0, 25, 0,    4'b0010, {64'd0, 32'd9, 32'd0}, {64'd0, 32'd9, 32'd0}, 0, 1, 20, 0, 1, 4'b0000, 19};
    tbl[8] = '{1'b1, 2,  5,    4'b0001, {96'd0, 32'd33}, {96'd0, 32'd32}, 1100, 4, 20, 0, 1, 4'b0001, 1176};
    tbl[9] = '{1'b1, 2,  1176, 4'b0000, 128'd0, 128'd0, 1100, 4, 20, 1, 0, 4'b0000, 1176};

    repeat (2) @(posedge clk);
    #1;
    chk("reset state", 128'({busy, done, pass, timeout, halt_req, fail_vec, cycle_count, snap_pc}), 128'd0);
    @(negedge clk); reset = 0;

    for (int t = 0; t < 10; t++) begin
      for (int e = 0; e < 64; e++) begin
        pcs[e]  = tbl[t].base + tbl[t].step * 32'(e - 1);
        prbs[e] = tbl[t].prb;
      end
      run($sformatf("vec%0d", t), tbl[t].m, tbl[t].sc, tbl[t].spc, tbl[t].mask, tbl[t].ev,
          tbl[t].e_trig, tbl[t].e_pass, tbl[t].e_to, tbl[t].e_fv, tbl[t].e_snap);
    end

    for (int r = 0; r < 30; r++) begin
      logic m; logic [31:0] sc, spc, sp; logic [3:0] mask, fv; logic [127:0] ev;
      int k; logic p, to;
      m = 1'($urandom_range(0, 1));
      sc = $urandom_range(0, 24);
      spc = $urandom_range(0, 15) * 4;
      mask = 4'($urandom);
      for (int i = 0; i < N; i++) ev[i*W +: W] = $urandom_range(0, 3);
      for (int e = 0; e < 64; e++) begin
        pcs[e] = $urandom_range(0, 15) * 4;
        for (int i = 0; i < N; i++) prbs[e][i*W +: W] = $urandom_range(0, 3);
      end
      model(m, sc, spc, mask, ev, k, p, to, fv, sp);
      run($sformatf("rnd%0d", r), m, sc, spc, mask, ev, k, p, to, fv, sp);
    end

    // start pulsed mid-RUN is ignored
    for (int e = 0; e < 64; e++) begin pcs[e] = 32'(e); prbs[e] = '0; end
    arm(1'b0, 10, 0, 4'b0000, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); stop_cycle = 2; start = 1;
    @(posedge clk); #1; start = 0;
    chk("start in run", 128'({busy, cycle_count}), 128'({1'b1, 32'd4}));
    begin
      int lat;
      lat = 0;
      for (int e = 1; e <= 40; e++) begin
        @(posedge clk); #1;
        if (done) begin lat = e; break; end
      end
      chk("start in run done", 128'({lat != 0, cycle_count, pass}), 128'({1'b1, 32'd10, 1'b1}));
    end

    // reset mid-RUN abandons the run
    arm(1'b0, 10, 0, 4'b0001, 128'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("pre-reset count", 128'(cycle_count), 128'd5);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    chk("reset in run", 128'({busy, done, pass, timeout, halt_req, fail_vec, cycle_count, snap_pc}), 128'd0);
    @(negedge clk); reset = 0;
    for (int e = 0; e < 64; e++) begin pcs[e] = 200 + 32'(e - 1); prbs[e] = tbl[0].prb; end
    run("after reset", tbl[0].m, tbl[0].sc, tbl[0].spc, tbl[0].mask, tbl[0].ev,
        tbl[0].e_trig, tbl[0].e_pass, tbl[0].e_to, tbl[0].e_fv, tbl[0].e_snap);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
